pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It merges stall requests from IF, ID and MEM into the stall vector consumed by every pipe_* register. It sequences branch-mispredict recovery: discard of IF/ID and ID/EX contents, drain of any in-flight instruction fetch, and a one-cycle PC redirect. It sits beside the pipeline registers and drives their stall and discard inputs and the PC redirect port.

Parameters:
ADDR_W, 32, width of branch target / redirect PC
CNT_W, 32, width of performance counters (used only with PIPE_CTRL_PERF_EN)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
if_req  in  1  IF waiting on memory; hold PC and IF
if_busy  in  1  IF has an instruction fetch in flight that cannot be aborted
id_req  in  1  ID load-use hazard; hold PC..ID, bubble into EX
mem_req  in  1  MEM stage memory access busy; hold PC..MEM, bubble into WB
ex_br_miss  in  1  EX detected a mispredicted branch/jump
ex_br_target  in  ADDR_W  correct next PC for ex_br_miss
stall  out  6  stall[0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB
discard  out  1  clear IF/ID and ID/EX registers at next edge
redirect  out  1  load PC from redirect_pc this cycle
redirect_pc  out  ADDR_W  redirect target
busy  out  1  recovery sequence in progress (state != RUN)
stall_cycles  out  CNT_W  cycles with stall[0]=1 (PIPE_CTRL_PERF_EN only)
flush_count  out  CNT_W  accepted mispredicts (PIPE_CTRL_PERF_EN only)

Behaviour:
- Reset (reset_n low, async): state=RUN, target register=0, counters=0; all outputs 0 while reset_n low.
- Pipe-register convention: stage k holds while stall[k]=1; a bubble is inserted downstream when stall[k]=1 and stall[k+1]=0. stall[5] is always 0.
- Stall priority, combinational:
  - mem_req gives 6'b011111.
  - else id_req (masked outside RUN) gives 6'b000111.
  - else if_req gives 6'b000011.
  - else 6'b000000.
- FSM states: RUN, DRAIN, REDIRECT.
- RUN:
  - Mispredict accepted when ex_br_miss=1 and mem_req=0. If mem_req=1, EX is held and the branch re-presents later.
  - On accept: discard=1 in the same cycle, and ex_br_target is latched.
  - Next state: DRAIN if if_busy=1, else REDIRECT.
- DRAIN:
  - discard=1 and stall[0]=1 held; IF completes its fetch and the result is discarded.
  - Leaves to REDIRECT in the cycle after if_busy is sampled 0.
- REDIRECT:
  - redirect=1 and discard=1; redirect_pc = latched target.
  - stall[1:0] forced 0 unless mem_req=1.
  - If mem_req=1, stays in REDIRECT with redirect held; otherwise returns to RUN.
- Latency: a mispredict accepted at edge N with if_busy=0 gives redirect=1 during cycle N+1 and RUN at edge N+2.
- Outside RUN, ex_br_miss is ignored: EX has been discarded, so it is a spurious input. The latched target is unchanged.
- redirect_pc outputs the latched target in all states; it is valid only while redirect=1.
- Async reset mid-recovery returns to RUN immediately; no redirect is issued.

Optional Feature:
PIPE_CTRL_PERF_EN:
- When defined:
  - stall_cycles increments every cycle with stall[0]=1.
  - flush_count increments on each accepted mispredict.
  - Both wrap modulo 2^CNT_W and reset to 0.
- When undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- mem_req=1 with id_req=1 and if_req=1 -> stall=6'b011111; drop mem_req -> stall=6'b000111 on the same cycle.
- ex_br_miss=1, target=32'h0000_1040, if_busy=0 at edge N -> discard=1 in cycle N; redirect=1 and redirect_pc=32'h1040 in cycle N+1; busy=0 after edge N+2.
- Mispredict with if_busy=1 for 3 cycles -> DRAIN for 3 cycles with discard=1 and stall[0]=1; redirect pulses exactly once after if_busy falls.
- ex_br_miss=1 with mem_req=1 for 2 cycles -> no discard and busy=0 for those cycles; accept occurs on the first cycle with mem_req=0.
- In REDIRECT with mem_req=1 for 2 cycles -> redirect held 3 cycles; id_req=1 during DRAIN -> stall[2] stays 0.
- With PIPE_CTRL_PERF_EN: 5 stalled cycles and 2 mispredicts -> stall_cycles=5 and flush_count=2; reset_n pulse -> both 0 asynchronously.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges stall requests and runs mispredict recovery.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic              if_busy,
  input  logic              id_req,
  input  logic              mem_req,
  input  logic              ex_br_miss,
  input  logic [ADDR_W-1:0] ex_br_target,
  output logic [5:0]        stall,
  output logic              discard,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] target_reg;
  logic              in_run;
  logic              id_req_eff;
  logic              accept;
  logic [4:0]        base_stall;
  logic [5:0]        stall_next;
  logic              discard_next;
  logic              redirect_next;

  assign in_run     = (state_reg == RUN);
  assign id_req_eff = id_req & in_run;

  // Request masks nest (MEM covers ID covers IF), so the priority chain reduces to per-bit ORs.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stall
      if (gi <= 1) begin : g_pc_if
        assign base_stall[gi] = mem_req | id_req_eff | if_req;
      end else if (gi == 2) begin : g_id
        assign base_stall[gi] = mem_req | id_req_eff;
      end else begin : g_ex_mem
        assign base_stall[gi] = mem_req;
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    stall_next    = {1'b0, base_stall};
    discard_next  = 1'b0;
    redirect_next = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      RUN: begin
        if (ex_br_miss && !mem_req) begin
          accept       = 1'b1;
          discard_next = 1'b1;
          state_next   = if_busy ? DRAIN : REDIRECT;
        end
      end
      DRAIN: begin
        discard_next  = 1'b1;
        stall_next[0] = 1'b1;
        if (!if_busy) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        discard_next  = 1'b1;
        redirect_next = 1'b1;
        if (!mem_req) begin
          stall_next[1:0] = 2'b00;
          state_next      = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= RUN;
      target_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        target_reg <= ex_br_target;
      end
    end
  end

  // Gate the combinational outputs so every output reads 0 while reset is asserted.
  assign stall       = reset_n ? stall_next : 6'b000000;
  assign discard     = reset_n & discard_next;
  assign redirect    = reset_n & redirect_next;
  assign redirect_pc = target_reg;
  assign busy        = ~in_run;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] flush_count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (stall[0]) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      end
      if (accept) begin
        flush_count_reg <= flush_count_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl, with hand sequences for reset and counter corners.
module tb_pipe_ctrl;

  logic        clock;
  logic        reset_n;
  logic        if_req, if_busy, id_req, mem_req, ex_br_miss;
  logic [31:0] ex_br_target;
  logic [5:0]  stall;
  logic        discard, redirect, busy;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam int EXP_STALLS = 5;
  localparam int EXP_FLUSH  = 2;
`else
  localparam int EXP_STALLS = 0;
  localparam int EXP_FLUSH  = 0;
`endif

  pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .if_req       (if_req),
    .if_busy      (if_busy),
    .id_req       (id_req),
    .mem_req      (mem_req),
    .ex_br_miss   (ex_br_miss),
    .ex_br_target (ex_br_target),
    .stall        (stall),
    .discard      (discard),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .busy         (busy),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        if_req;
    logic        if_busy;
    logic        id_req;
    logic        mem_req;
    logic        miss;
    logic [31:0] tgt;
    logic [5:0]  e_stall;
    logic        e_disc;
    logic        e_redir;
    logic        e_busy;
    logic [31:0] e_rpc;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic i_if, input logic i_ifb, input logic i_id,
                              input logic i_mem, input logic i_miss, input logic [31:0] i_tgt,
                              input logic [5:0] o_stall, input logic o_disc, input logic o_redir,
                              input logic o_busy, input logic [31:0] o_rpc);
    vec_t v;
    v.if_req  = i_if;
    v.if_busy = i_ifb;
    v.id_req  = i_id;
    v.mem_req = i_mem;
    v.miss    = i_miss;
    v.tgt     = i_tgt;
    v.e_stall = o_stall;
    v.e_disc  = o_disc;
    v.e_redir = o_redir;
    v.e_busy  = o_busy;
    v.e_rpc   = o_rpc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, required %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic i_if, input logic i_ifb, input logic i_id,
                       input logic i_mem, input logic i_miss, input logic [31:0] i_tgt);
    if_req       = i_if;
    if_busy      = i_ifb;
    id_req       = i_id;
    mem_req      = i_mem;
    ex_br_miss   = i_miss;
    ex_br_target = i_tgt;
  endtask

  task automatic chk_outs(input string nm, input int idx, input logic [5:0] e_stall,
                          input logic e_disc, input logic e_redir, input logic e_busy,
                          input logic [31:0] e_rpc);
    chk({nm, ".stall"},    idx, 32'(stall),    32'(e_stall));
    chk({nm, ".discard"},  idx, 32'(discard),  32'(e_disc));
    chk({nm, ".redirect"}, idx, 32'(redirect), 32'(e_redir));
    chk({nm, ".busy"},     idx, 32'(busy),     32'(e_busy));
    chk({nm, ".rpc"},      idx, redirect_pc,   e_rpc);
    $display("%s %0d: stall=%b discard=%b redirect=%b busy=%b redirect_pc=%h",
             nm, idx, stall, discard, redirect, busy, redirect_pc);
  endtask

  initial begin
    //                 if ifb id mem miss tgt            stall      dis red bsy rpc
    vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,1'b0,1'b0,32'h0);
    vecs[1]  = mk(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,        6'b011111,1'b0,1'b0,1'b0,32'h0);
    vecs[2]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000111,1'b0,1'b0,1'b0,32'h0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000011,1'b0,1'b0,1'b0,32'h0);
    vecs[4]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000111,1'b0,1'b0,1'b0,32'h0);
    // Mispredict with no fetch in flight: discard now, redirect next cycle, RUN after.
    vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_1040,6'b000000,1'b1,1'b0,1'b0,32'h0);
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b1,1'b1,1'b1,32'h0000_1040);
    vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,1'b0,1'b0,32'h0000_1040);
    // Mispredict blocked by mem_req for two cycles, then accepted with a fetch in flight.
    vecs[8]  = mk(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_2000,6'b011111,1'b0,1'b0,1'b0,32'h0000_1040);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_2000,6'b011111,1'b0,1'b0,1'b0,32'h0000_1040);
    vecs[10] = mk(1'b0,1'b1,1'b0,1'b0,1'b1,32'h0000_2000,6'b000000,1'b1,1'b0,1'b0,32'h0000_1040);
    // DRAIN: id_req masked, spurious miss ignored, PC held.
    vecs[11] = mk(1'b0,1'b1,1'b1,1'b0,1'b1,32'h0000_3000,6'b000001,1'b1,1'b0,1'b1,32'h0000_2000);
    vecs[12] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        6'b000001,1'b1,1'b0,1'b1,32'h0000_2000);
    vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000001,1'b1,1'b0,1'b1,32'h0000_2000);
    // REDIRECT held by mem_req, then released with if/id requests suppressed.
    vecs[14] = mk(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,        6'b011111,1'b1,1'b1,1'b1,32'h0000_2000);
    vecs[15] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        6'b011111,1'b1,1'b1,1'b1,32'h0000_2000);
    vecs[16] = mk(1'b1,1'b0,1'b1,1'b0,1'b1,32'h0000_4000,6'b000000,1'b1,1'b1,1'b1,32'h0000_2000);
    vecs[17] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,1'b0,1'b0,32'h0000_2000);

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    #1;
    chk_outs("reset", 0, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.stall_cycles", 0, stall_cycles, 32'h0);
    chk("reset.flush_count",  0, flush_count,  32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      drive(vecs[i].if_req, vecs[i].if_busy, vecs[i].id_req, vecs[i].mem_req,
            vecs[i].miss, vecs[i].tgt);
      #1;
      chk_outs("vec", i, vecs[i].e_stall, vecs[i].e_disc, vecs[i].e_redir,
               vecs[i].e_busy, vecs[i].e_rpc);
    end

    // Async reset while draining: back to RUN at once, no redirect afterwards.
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_5555);
    #1;
    chk_outs("arst", 0, 6'b000000, 1'b1, 1'b0, 1'b0, 32'h0000_2000);
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk_outs("arst", 1, 6'b000001, 1'b1, 1'b0, 1'b1, 32'h0000_5555);
    #1;
    reset_n = 1'b0;
    #1;
    chk_outs("arst", 2, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk_outs("post_arst", i, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    end

    // Counters: five PC-stall cycles and two accepted mispredicts.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk_outs("perf", 0, 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    #1;
    chk_outs("perf", 1, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0000_0200);
    chk("perf.stall_cycles", 0, stall_cycles, 32'(EXP_STALLS));
    chk("perf.flush_count",  0, flush_count,  32'(EXP_FLUSH));
    $display("perf: stall_cycles=%0d flush_count=%0d", stall_cycles, flush_count);
    #1;
    reset_n = 1'b0;
    #1;
    chk("perf_rst.stall_cycles", 0, stall_cycles, 32'h0);
    chk("perf_rst.flush_count",  0, flush_count,  32'h0);
    chk("perf_rst.rpc",          0, redirect_pc,  32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
